acc_window_dump: RTL and testbench



---
 rtl/acc_window_dump.sv | 129 ++++++++++++
 tb/tb_acc_window_dump.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_window_dump.sv
// acc_window_dump: control and drain stage placed after an accumulator.
//
// The block drives the accumulator's clear and enable. It counts a programmed
// window of valid samples, then captures the accumulator sum into a one-entry
// output register. The consumer reads that register through a valid/ready
// handshake. Windows can be single-shot or continuous (back-to-back).
//
// Ports:
//   iClk, iRstN      clock; asynchronous active-low reset
//   iStart           start pulse, honoured only when idle
//   iCont, iLen      continuous flag and window length, latched with iStart
//   iValid           upstream sample strobe (also qualifies accumulator data)
//   iAccData         accumulator sum (BITWIDTH+1 bits)
//   oAccEn, oAccClr  accumulator enable / clear
//   oValid, iReady   result handshake
//   oData            captured window sum
//   oBusy            high whenever a window is in progress
//   oOverrun         sticky: a sample arrived while it could not be accepted
module acc_window_dump #(
  parameter int BITWIDTH = 32,
  parameter int CNTW     = 16
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iCont,
  input  logic [CNTW-1:0]     iLen,
  input  logic                iValid,
  input  logic [BITWIDTH:0]   iAccData,
  output logic                oAccEn,
  output logic                oAccClr,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH:0]   oData,
  output logic                oBusy,
  output logic                oOverrun
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] len_q;
  logic            cont_q;
  logic            load;   // capture the sum into the output register
  logic            last;   // final sample of the window accepted this cycle
  logic            drop;   // a sample arrived while it could not be accepted

  // Next state and accumulator controls. Clear exists only in CLEAR and
  // enable only in RUN, so the two can never overlap.
  always_comb begin
    state_nxt = state;
    oAccEn    = 1'b0;
    oAccClr   = 1'b0;
    load      = 1'b0;
    last      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) state_nxt = CLEAR;
      end
      CLEAR: begin
        oAccClr   = 1'b1;
        drop      = iValid;
        // A zero-length window skips RUN and captures the freshly cleared sum.
        state_nxt = (len_q != '0) ? RUN : CAPTURE;
      end
      RUN: begin
        oAccEn = iValid;
        last   = iValid && (cnt == len_q - CNTW'(1));
        if (last) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        drop = iValid;
        // Load when the output register is empty, or when it drains in the
        // same cycle. Otherwise hold here so the accumulator keeps its sum.
        load = !oValid || iReady;
        if (load) state_nxt = cont_q ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oBusy = (state != IDLE);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      cont_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && iStart) begin
        len_q  <= iLen;
        cont_q <= iCont;
      end
      // The count stops at len at most (len <= 2^CNTW-1), so it cannot wrap.
      if (state == CLEAR)
        cnt <= '0;
      else if (state == RUN && iValid)
        cnt <= cnt + CNTW'(1);
    end
  end

  // One-entry output register. A load in the drain cycle keeps oValid high.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (load) begin
      oValid <= 1'b1;
      oData  <= iAccData;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

  // The overrun flag is cleared only by an accepted start.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      oOverrun <= 1'b0;
    else if (state == IDLE && iStart)
      oOverrun <= 1'b0;
    else if (drop)
      oOverrun <= 1'b1;
  end

endmodule

// File: tb/tb_acc_window_dump.sv
// Testbench for acc_window_dump (BITWIDTH=8, CNTW=4).
// A small behavioural accumulator closes the loop. Fixed vectors, hand-written
// corner sequences and random single-shot windows are checked against sums
// the bench computes from the samples it sends.
module tb_acc_window_dump;
  localparam int BW = 8;
  localparam int CW = 4;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b1;
  logic          iStart = 1'b0, iCont = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [CW-1:0] iLen = '0;
  logic [BW:0]   iAccData;
  logic          oAccEn, oAccClr, oValid, oBusy, oOverrun;
  logic [BW:0]   oData;
  logic [BW-1:0] smp = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 iClk = ~iClk;

  acc_window_dump #(.BITWIDTH(BW), .CNTW(CW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iCont(iCont), .iLen(iLen),
    .iValid(iValid), .iAccData(iAccData), .oAccEn(oAccEn), .oAccClr(oAccClr),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oBusy(oBusy),
    .oOverrun(oOverrun)
  );

  // Behavioural accumulator: wraps at BW+1 bits.
  logic [BW:0] acc;
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)       acc <= '0;
    else if (oAccClr) acc <= '0;
    else if (oAccEn)  acc <= acc + {1'b0, smp};
  end
  assign iAccData = acc;

  typedef struct packed {
    logic [3:0]       len;
    logic [4:0]       ncyc;
    logic [19:0]      vmask;
    logic [19:0][7:0] smp;
    logic [8:0]       exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic mid();
    @(negedge iClk);
  endtask

  // Single-shot window with iReady held high; checks enable, latency and busy.
  task automatic run_window(input vec_t v);
    iStart = 1'b1; iLen = v.len; iCont = 1'b0; iValid = 1'b0; iReady = 1'b1;
    mid(); chk("idle_busy", oBusy, 0);
    step();
    iStart = 1'b0; iLen = CW'($urandom); iCont = 1'($urandom);
    mid(); chk("clear_clr", oAccClr, 1); chk("clear_en", oAccEn, 0); chk("clear_busy", oBusy, 1);
    step();
    for (int i = 0; i < int'(v.ncyc); i++) begin
      iValid = v.vmask[i];
      smp    = v.vmask[i] ? v.smp[i] : BW'($urandom);
      mid(); chk("run_en", oAccEn, v.vmask[i]); chk("run_clr", oAccClr, 0);
      step();
    end
    iValid = 1'b0;
    mid(); chk("cap_valid_low", oValid, 0); chk("cap_en", oAccEn, 0); chk("cap_clr", oAccClr, 0);
    step();
    mid(); chk("res_valid", oValid, 1); chk("res_data", oData, v.exp); chk("res_busy", oBusy, 0);
    step();
    mid(); chk("after_valid", oValid, 0); chk("after_busy", oBusy, 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, sum;
    bit done;

    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].len = 4; tbl[0].ncyc = 4; tbl[0].vmask = 20'hF;
    tbl[0].smp[0] = 10; tbl[0].smp[1] = 20; tbl[0].smp[2] = 30; tbl[0].smp[3] = 40; tbl[0].exp = 100;
    tbl[1].len = 3; tbl[1].ncyc = 6; tbl[1].vmask = 20'b101001;
    tbl[1].smp[0] = 5; tbl[1].smp[3] = 7; tbl[1].smp[5] = 9; tbl[1].exp = 21;
    tbl[2].len = 0; tbl[2].ncyc = 0; tbl[2].exp = 0;
    tbl[3].len = 15; tbl[3].ncyc = 15; tbl[3].vmask = 20'h7FFF;
    for (int i = 0; i < 15; i++) tbl[3].smp[i] = 8'd255;
    tbl[3].exp = 9'(3825 % 512);
    tbl[4].len = 1; tbl[4].ncyc = 1; tbl[4].vmask = 20'h1; tbl[4].smp[0] = 9; tbl[4].exp = 9;
    tbl[5].len = 5; tbl[5].ncyc = 7; tbl[5].vmask = 20'd117;
    tbl[5].smp[0] = 1; tbl[5].smp[2] = 2; tbl[5].smp[4] = 3; tbl[5].smp[5] = 4; tbl[5].smp[6] = 5;
    tbl[5].exp = 15;

    // Reset state
    #1 iRstN = 1'b0;
    #1;
    chk("rst_valid", oValid, 0); chk("rst_data", oData, 0); chk("rst_ovr", oOverrun, 0);
    chk("rst_en", oAccEn, 0); chk("rst_clr", oAccClr, 0); chk("rst_busy", oBusy, 0);
    step(); step();
    iRstN = 1'b1;
    step();

    // iValid in IDLE is ignored and does not flag overrun
    iValid = 1'b1; smp = 8'd3;
    step(); step();
    mid(); chk("idle_ovr", oOverrun, 0); chk("idle_en", oAccEn, 0);
    iValid = 1'b0;
    step();

    // Table-driven single-shot windows
    for (int i = 0; i < 6; i++) run_window(tbl[i]);

    // Continuous mode with a downstream stall
    iStart = 1'b1; iCont = 1'b1; iLen = 2; iReady = 1'b0;
    step();
    iStart = 1'b0; iCont = 1'b0;
    mid(); chk("cont_clr1", oAccClr, 1);
    step();
    iValid = 1'b1; smp = 1; step();
    smp = 2; step();
    iValid = 1'b0;
    mid(); chk("cont_cap1_valid", oValid, 0);
    step();
    mid(); chk("cont_res1_valid", oValid, 1); chk("cont_res1_data", oData, 3); chk("cont_clr2", oAccClr, 1);
    step();
    iValid = 1'b1; smp = 3; step();
    smp = 4; step();
    smp = 50;  // arrives during the stall and must be dropped
    mid(); chk("stall_en", oAccEn, 0); chk("stall_data", oData, 3); chk("stall_valid", oValid, 1);
    chk("stall_ovr_pre", oOverrun, 0);
    step();
    iValid = 1'b0;
    mid(); chk("stall_ovr", oOverrun, 1); chk("stall_en2", oAccEn, 0); chk("stall_busy", oBusy, 1);
    chk("stall_data2", oData, 3);
    step();
    iReady = 1'b1;
    mid(); chk("drain_valid", oValid, 1); chk("drain_data", oData, 3);
    step();
    iReady = 1'b0;
    mid(); chk("b2b_valid", oValid, 1); chk("b2b_data", oData, 7); chk("b2b_clr", oAccClr, 1);
    step();
    // Continuous mode runs until reset
    iValid = 1'b1; smp = 5;
    #2 iRstN = 1'b0;
    #1;
    chk("abort_valid", oValid, 0); chk("abort_data", oData, 0); chk("abort_ovr", oOverrun, 0);
    chk("abort_en", oAccEn, 0); chk("abort_busy", oBusy, 0);
    iValid = 1'b0;
    step();
    iRstN = 1'b1;
    step();

    // Reset mid-RUN after 2 of 4 samples, then a fresh 1-sample window
    iStart = 1'b1; iLen = 4; iReady = 1'b1;
    step();
    iStart = 1'b0;
    step();
    iValid = 1'b1; smp = 11; step();
    smp = 12; step();
    smp = 13;
    #2 iRstN = 1'b0;
    #1;
    chk("midrun_en", oAccEn, 0); chk("midrun_busy", oBusy, 0); chk("midrun_valid", oValid, 0);
    chk("midrun_clr", oAccClr, 0); chk("midrun_data", oData, 0);
    iValid = 1'b0;
    step();
    iRstN = 1'b1;
    step();
    run_window(tbl[4]);

    // Overrun: set by a sample in CLEAR, sticky in IDLE, cleared by a start
    iStart = 1'b1; iLen = 1; iCont = 1'b0; iReady = 1'b1;
    step();
    iStart = 1'b0; iValid = 1'b1; smp = 77;
    mid(); chk("ovr_clear_pre", oOverrun, 0);
    step();
    smp = 6;
    mid(); chk("ovr_set", oOverrun, 1); chk("ovr_run_en", oAccEn, 1);
    step();
    iValid = 1'b0;
    step();
    mid(); chk("ovr_data", oData, 6); chk("ovr_res_valid", oValid, 1);
    step();
    iValid = 1'b1;
    step();
    mid(); chk("ovr_sticky", oOverrun, 1);
    iValid = 1'b0; iStart = 1'b1; iLen = 0;
    step();
    iStart = 1'b0;
    mid(); chk("ovr_cleared", oOverrun, 0);
    step(); step();
    mid(); chk("len0_valid", oValid, 1); chk("len0_data", oData, 0);
    step(); step();

    // Random single-shot windows with random gaps and random drain back-pressure
    for (int w = 0; w < 40; w++) begin
      L = $urandom_range(0, 15);
      sum = 0;
      done = 0;
      iStart = 1'b1; iLen = CW'(L); iCont = 1'b0; iReady = 1'b0;
      step();
      iStart = 1'b0; iLen = CW'($urandom); iCont = 1'($urandom);
      step();
      for (int s = 0; s < L; s++) begin
        repeat ($urandom_range(0, 2)) begin
          iValid = 1'b0; smp = BW'($urandom); step();
        end
        iValid = 1'b1; smp = BW'($urandom); sum += int'(smp);
        step();
      end
      iValid = 1'b0;
      mid(); chk("rnd_early_valid", oValid, 0);
      step();
      for (int k = 0; k < 40 && !done; k++) begin
        iReady = 1'($urandom);
        mid();
        if (k == 0) chk("rnd_latency", oValid, 1);
        if (oValid) chk("rnd_data", oData, 32'(sum % 512));
        if (oValid && iReady) done = 1;
        step();
      end
      if (!done) chk("rnd_drain_timeout", 0, 1);
      iReady = 1'b0;
      mid(); chk("rnd_idle_valid", oValid, 0); chk("rnd_idle_busy", oBusy, 0); chk("rnd_ovr", oOverrun, 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
